ttt_move_check: RTL and testbench



---
 rtl/ttt_pkg.sv | 40 ++++
 rtl/ttt_win_detect.sv | 25 ++
 rtl/ttt_move_check.sv | 114 +++++++++++
 tb/tb_ttt_move_check.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe encodings: player codes, game states, board width, win-line masks.
// Latency: none (constants, types and a pure helper function only).
// Backpressure: not applicable.
package ttt_pkg;

    localparam int BOARD_W   = 9;
    localparam int NUM_LINES = 8;

    typedef enum logic [1:0] {
        PLAYER_A = 2'b01,
        PLAYER_B = 2'b10
    } player_e;

    typedef enum logic [2:0] {
        ST_INIT = 3'd0,
        ST_PLAY = 3'd1,
        ST_AWIN = 3'd2,
        ST_BWIN = 3'd3,
        ST_DRAW = 3'd4
    } state_e;

    // Square k is bit k, row-major, bit 0 top-left
    localparam logic [BOARD_W-1:0] WIN_LINES [NUM_LINES] = '{
        9'b000_000_111,   // row 0
        9'b000_111_000,   // row 1
        9'b111_000_000,   // row 2
        9'b001_001_001,   // column 0
        9'b010_010_010,   // column 1
        9'b100_100_100,   // column 2
        9'b100_010_001,   // main diagonal
        9'b001_010_100    // anti diagonal
    };

    // A board is full when every square is claimed by one of the players
    function automatic logic board_full(input logic [BOARD_W-1:0] a_half,
                                        input logic [BOARD_W-1:0] b_half);
        return (a_half | b_half) == {BOARD_W{1'b1}};
    endfunction

endpackage

// File: rtl/ttt_win_detect.sv
// Flags whether a single player's 9-square half covers any of the 8 win lines.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the input board continuously.
module ttt_win_detect
    import ttt_pkg::*;
(
    input  logic [BOARD_W-1:0] board,
    output logic               win
);

    logic line_hit;

    // OR together a full-match test against every win-line mask
    always_comb begin
        line_hit = 1'b0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if ((board & WIN_LINES[i]) == WIN_LINES[i]) begin
                line_hit = 1'b1;
            end
        end
    end

    assign win = line_hit;

endmodule

// File: rtl/ttt_move_check.sv
// Checks a proposed board for a legal single move, derives the next game state, runs the turn timer.
// Latency: valid_move/next_state combinational (zero cycles); count registered, updates each clk edge.
// Backpressure: none; the commit logic gates next_state with valid_move and may ignore both freely.
module ttt_move_check
    import ttt_pkg::*;
#(
    parameter logic [3:0] INIT_TIME = 4'd10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  turn,
    input  logic [2:0]  state,
    input  logic [17:0] curr_move,
    input  logic [17:0] next_move,
    output logic [3:0]  count,
    output logic        valid_move,
    output logic [2:0]  next_state
);

    // ------------------------------------------------------------------
    // Turn timer
    // ------------------------------------------------------------------
    logic [3:0] count_q, count_d;
    logic [1:0] turn_prev_q, turn_prev_d;

    // Reload on leaving PLAY or on a turn hand-over; otherwise count down to zero and hold
    always_comb begin
        count_d     = count_q;
        turn_prev_d = turn;
        if ((state != ST_PLAY) || (turn != turn_prev_q)) begin
            count_d = INIT_TIME;
        end else if (count_q != 4'd0) begin
            count_d = count_q - 4'd1;
        end
    end

    // Timer and previous-turn registers; reset reloads the timer immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q     <= INIT_TIME;
            turn_prev_q <= PLAYER_A;
        end else begin
            count_q     <= count_d;
            turn_prev_q <= turn_prev_d;
        end
    end

    assign count = count_q;

    // ------------------------------------------------------------------
    // Move legality
    // ------------------------------------------------------------------
    logic [BOARD_W-1:0] next_a, next_b;
    logic [17:0]        diff;
    logic               state_ok;
    logic               time_ok;
    logic               no_clear;
    logic               one_change;
    logic               in_own_half;
    logic               no_overlap;

    assign next_a = next_move[BOARD_W-1:0];
    assign next_b = next_move[2*BOARD_W-1:BOARD_W];
    assign diff   = curr_move ^ next_move;

    // Evaluate each legality condition separately, then AND them together
    always_comb begin
        state_ok    = (state == ST_INIT) || (state == ST_PLAY);
        time_ok     = (count_q != 4'd0);
        no_clear    = ((curr_move & ~next_move) == 18'd0);
        // Non-zero and a power of two: exactly one square changed
        one_change  = (diff != 18'd0) && ((diff & (diff - 18'd1)) == 18'd0);
        // The changed square must sit in the mover's half; illegal turn codes never qualify
        in_own_half = 1'b0;
        if (turn == PLAYER_A) begin
            in_own_half = (diff[2*BOARD_W-1:BOARD_W] == '0);
        end else if (turn == PLAYER_B) begin
            in_own_half = (diff[BOARD_W-1:0] == '0);
        end
        no_overlap  = ((next_a & next_b) == '0);
        valid_move  = state_ok && time_ok && no_clear && one_change &&
                      in_own_half && no_overlap;
    end

    // ------------------------------------------------------------------
    // Next game state
    // ------------------------------------------------------------------
    logic a_win, b_win;

    ttt_win_detect u_win_a (
        .board (next_a),
        .win   (a_win)
    );

    ttt_win_detect u_win_b (
        .board (next_b),
        .win   (b_win)
    );

    // Terminal states hold; otherwise A win beats B win beats full-board draw
    always_comb begin
        next_state = ST_PLAY;
        if ((state == ST_AWIN) || (state == ST_BWIN) || (state == ST_DRAW)) begin
            next_state = state;
        end else if (a_win) begin
            next_state = ST_AWIN;
        end else if (b_win) begin
            next_state = ST_BWIN;
        end else if (board_full(next_a, next_b)) begin
            next_state = ST_DRAW;
        end
    end

endmodule

// File: tb/tb_ttt_move_check.sv
// Directed bench for ttt_move_check: timer countdown/reload/reset, move legality, next-state mux.
// Latency: combinational outputs checked 1 time unit after input changes; count checked 1 unit after each edge.
// Backpressure: not applicable.
module tb_ttt_move_check;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  turn;
    logic [2:0]  state;
    logic [17:0] curr_move;
    logic [17:0] next_move;
    logic [3:0]  count;
    logic        valid_move;
    logic [2:0]  next_state;

    int checks   = 0;
    int failures = 0;

    localparam logic [2:0] S_INIT = 3'd0;
    localparam logic [2:0] S_PLAY = 3'd1;
    localparam logic [2:0] S_AWIN = 3'd2;
    localparam logic [2:0] S_BWIN = 3'd3;
    localparam logic [2:0] S_DRAW = 3'd4;
    localparam logic [1:0] T_A    = 2'b01;
    localparam logic [1:0] T_B    = 2'b10;

    ttt_move_check #(.INIT_TIME(4'd10)) dut (
        .clk        (clk),
        .reset      (reset),
        .turn       (turn),
        .state      (state),
        .curr_move  (curr_move),
        .next_move  (next_move),
        .count      (count),
        .valid_move (valid_move),
        .next_state (next_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        turn      = T_A;
        state     = S_INIT;
        curr_move = 18'h0;
        next_move = 18'h0;
        #2;
        check("reset_count", 32'(count), 32'd10);
        check("reset_nomove_invalid", 32'(valid_move), 32'd0);
        #10;
        reset = 1'b0;

        // 1: countdown in PLAY with a constant turn, saturating at zero
        state = S_PLAY;
        #1;
        check("cd_start", 32'(count), 32'd10);
        for (int i = 9; i >= 0; i--) begin
            step();
            check($sformatf("cd_%0d", i), 32'(count), 32'(i));
        end
        step();
        check("cd_sat0_a", 32'(count), 32'd0);
        step();
        check("cd_sat0_b", 32'(count), 32'd0);
        next_move = 18'h00010;
        #1;
        check("timeout_invalid", 32'(valid_move), 32'd0);
        check("timeout_next_state", 32'(next_state), 32'(S_PLAY));

        // 2: legal A move in PLAY, same move rejected for B
        state = S_INIT;
        step();
        check("reload_init", 32'(count), 32'd10);
        state = S_PLAY;
        #1;
        check("a_sq4_valid", 32'(valid_move), 32'd1);
        check("a_sq4_state", 32'(next_state), 32'(S_PLAY));
        turn = T_B;
        #1;
        check("b_wrong_half", 32'(valid_move), 32'd0);
        turn  = T_A;
        state = S_INIT;
        #1;
        check("init_state_play", 32'(next_state), 32'(S_PLAY));

        // 3: illegal moves from A holding square 0 (INIT keeps the timer loaded)
        curr_move = 18'h00001;
        next_move = 18'h00000;
        #1;
        check("clear_sq0", 32'(valid_move), 32'd0);
        next_move = 18'h00007;
        #1;
        check("two_a_bits", 32'(valid_move), 32'd0);
        turn      = T_B;
        next_move = 18'h00201;
        #1;
        check("overlap_sq0", 32'(valid_move), 32'd0);
        next_move = 18'h00401;
        #1;
        check("b_sq1_valid", 32'(valid_move), 32'd1);
        turn      = 2'b11;
        next_move = 18'h00003;
        #1;
        check("turn_11_invalid", 32'(valid_move), 32'd0);
        turn = 2'b00;
        #1;
        check("turn_00_invalid", 32'(valid_move), 32'd0);
        turn = T_A;
        #1;
        check("a_sq1_valid", 32'(valid_move), 32'd1);

        // 4: wins and sticky terminal states
        step();
        state     = S_PLAY;
        curr_move = 18'h0;
        next_move = 18'h00007;
        #1;
        check("a_row0_win", 32'(next_state), 32'(S_AWIN));
        next_move = 18'h22206;
        #1;
        check("b_diag_win", 32'(next_state), 32'(S_BWIN));
        state = S_AWIN;
        #1;
        check("awin_sticky", 32'(next_state), 32'(S_AWIN));
        state     = S_BWIN;
        next_move = 18'h00007;
        #1;
        check("bwin_sticky", 32'(next_state), 32'(S_BWIN));
        state     = S_DRAW;
        next_move = 18'h0;
        #1;
        check("draw_sticky", 32'(next_state), 32'(S_DRAW));
        state     = S_AWIN;
        next_move = 18'h00010;
        #1;
        check("terminal_invalid", 32'(valid_move), 32'd0);

        // 5: full boards
        step();
        state     = S_PLAY;
        next_move = 18'h234E5;
        #1;
        check("full_draw", 32'(next_state), 32'(S_DRAW));
        next_move = 18'h33067;
        #1;
        check("full_a_line", 32'(next_state), 32'(S_AWIN));
        next_move = 18'h38007;
        #1;
        check("a_over_b_priority", 32'(next_state), 32'(S_AWIN));

        // 6: turn hand-over reload, state reload, async reset
        state = S_INIT;
        step();
        check("pre6_reload", 32'(count), 32'd10);
        state = S_PLAY;
        for (int i = 0; i < 7; i++) begin
            step();
        end
        check("count_3", 32'(count), 32'd3);
        turn = T_B;
        step();
        check("turn_toggle_reload", 32'(count), 32'd10);
        step();
        check("after_toggle_dec", 32'(count), 32'd9);
        state = S_BWIN;
        step();
        check("terminal_reload", 32'(count), 32'd10);
        state = S_PLAY;
        step();
        step();
        check("pre_reset_8", 32'(count), 32'd8);
        reset = 1'b1;
        #1;
        check("async_reset", 32'(count), 32'd10);
        step();
        reset = 1'b0;
        check("reset_hold", 32'(count), 32'd10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
